sprite_mover: RTL and testbench

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover.sv | 137 +++++++++++++
 tb/tb_sprite_mover.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// Bouncing sprite position generator: moves a sprite diagonally, clamping and reversing at the screen edges.
// Optional macro SPRITE_TICK_BOTH_EDGES_EN: update on both CLK_update edges instead of rising edges only.
module sprite_mover #(
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned SPRITE_W = 16,
   parameter int unsigned SPRITE_H = 16,
   parameter int unsigned STEP     = 2,
   parameter int unsigned START_X  = 100,
   parameter int unsigned START_Y  = 100
) (
   input  logic       CLK_100MHz,
   input  logic       RST_n,
   input  logic       CLK_update,
   input  logic       start,
   input  logic       stop,
   input  logic       home,
   output logic [9:0] sprite_x,
   output logic [9:0] sprite_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic       running,
   output logic       hit_edge
);

   localparam int unsigned POS_W = 10;
   localparam logic [POS_W-1:0] XMAX    = POS_W'(SCREEN_W - SPRITE_W);
   localparam logic [POS_W-1:0] YMAX    = POS_W'(SCREEN_H - SPRITE_H);
   localparam logic [POS_W-1:0] STEP_V  = POS_W'(STEP);
   localparam logic [POS_W-1:0] HOME_X  = POS_W'(START_X);
   localparam logic [POS_W-1:0] HOME_Y  = POS_W'(START_Y);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [POS_W-1:0] x_q, x_d, y_q, y_d;
   logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic             running_q, running_d;
   logic             hit_q, hit_d;
   logic             sync1_q, sync2_q, sync3_q;
   logic             tick_c;
   logic [POS_W+1:0] step_x_c, step_y_c;

   // One axis move; result packs {clamped, new_dir, new_pos}. Sum is one bit wider so it never wraps.
   function automatic logic [POS_W+1:0] axis_step(input logic [POS_W-1:0] pos,
                                                  input logic             dir,
                                                  input logic [POS_W-1:0] lim);
      logic [POS_W:0] sum;
      sum = {1'b0, pos} + {1'b0, STEP_V};
      if (dir) begin
         if (sum >= {1'b0, lim}) return {1'b1, 1'b0, lim};
         else                    return {1'b0, 1'b1, sum[POS_W-1:0]};
      end else begin
         if (pos <= STEP_V) return {1'b1, 1'b1, POS_W'(0)};
         else               return {1'b0, 1'b0, pos - STEP_V};
      end
   endfunction

`ifdef SPRITE_TICK_BOTH_EDGES_EN
   assign tick_c = sync2_q ^ sync3_q;
`else
   assign tick_c = sync2_q & ~sync3_q;
`endif

   assign step_x_c = axis_step(x_q, dir_x_q, XMAX);
   assign step_y_c = axis_step(y_q, dir_y_q, YMAX);

   // Next-state: home beats stop beats start; ticks only move the sprite in RUN with no control active.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
      hit_d     = 1'b0;
      if (home) begin
         state_d = IDLE;
         x_d     = HOME_X;
         y_d     = HOME_Y;
         dir_x_d = 1'b1;
         dir_y_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!stop && start) state_d = RUN;
            end
            RUN: begin
               if (stop) begin
                  state_d = IDLE;
               end else if (tick_c) begin
                  x_d     = step_x_c[POS_W-1:0];
                  dir_x_d = step_x_c[POS_W];
                  y_d     = step_y_c[POS_W-1:0];
                  dir_y_d = step_y_c[POS_W];
                  hit_d   = step_x_c[POS_W+1] | step_y_c[POS_W+1];
               end
            end
            default: state_d = IDLE;
         endcase
      end
      running_d = (state_d == RUN);
   end

   always_ff @(posedge CLK_100MHz or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= IDLE;
         x_q       <= HOME_X;
         y_q       <= HOME_Y;
         dir_x_q   <= 1'b1;
         dir_y_q   <= 1'b1;
         running_q <= 1'b0;
         hit_q     <= 1'b0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         running_q <= running_d;
         hit_q     <= hit_d;
         sync1_q   <= CLK_update;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
      end
   end

   assign sprite_x = x_q;
   assign sprite_y = y_q;
   assign dir_x    = dir_x_q;
   assign dir_y    = dir_y_q;
   assign running  = running_q;
   assign hit_edge = hit_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: a behavioural model queues expected state per stimulus, compared at output time.
// Honours SPRITE_TICK_BOTH_EDGES_EN when defined for the build.
module tb_sprite_mover;

   localparam int XMAX = 624;
   localparam int YMAX = 464;
   localparam int STEP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_upd = 1'b0;
   logic       start = 1'b0, stop = 1'b0, home = 1'b0;
   logic [9:0] sx, sy;
   logic       odx, ody, orun, ohit;

   always #5 clk = ~clk;

   sprite_mover dut (
      .CLK_100MHz(clk), .RST_n(rst_n), .CLK_update(clk_upd),
      .start(start), .stop(stop), .home(home),
      .sprite_x(sx), .sprite_y(sy), .dir_x(odx), .dir_y(ody),
      .running(orun), .hit_edge(ohit)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       dx;
      logic       dy;
      logic       run;
      logic       hit;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   int   mx, my;
   logic mdx, mdy, mrun;

   function automatic exp_t obs();
      return '{x: sx, y: sy, dx: odx, dy: ody, run: orun, hit: ohit};
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("x=%0d y=%0d dx=%b dy=%b run=%b hit=%b", e.x, e.y, e.dx, e.dy, e.run, e.hit);
   endfunction

   task automatic model_reset();
      mx = 100; my = 100; mdx = 1'b1; mdy = 1'b1; mrun = 1'b0;
   endtask

   task automatic model_axis(inout int p, inout logic d, input int lim, inout logic clamp);
      if (d) begin
         if (p + STEP >= lim) begin p = lim; d = 1'b0; clamp = 1'b1; end
         else p = p + STEP;
      end else begin
         if (p <= STEP) begin p = 0; d = 1'b1; clamp = 1'b1; end
         else p = p - STEP;
      end
   endtask

   // Advance the model by one clock cycle of given inputs and queue the expected outputs.
   task automatic model_step(input logic tk, input logic st, input logic sp, input logic hm);
      logic clamp;
      clamp = 1'b0;
      if (hm) begin
         model_reset();
      end else if (mrun) begin
         if (sp) mrun = 1'b0;
         else if (tk) begin
            model_axis(mx, mdx, XMAX, clamp);
            model_axis(my, mdy, YMAX, clamp);
         end
      end else if (st && !sp) begin
         mrun = 1'b1;
      end
      sb.push_back('{x: 10'(mx), y: 10'(my), dx: mdx, dy: mdy, run: mrun, hit: clamp});
   endtask

   // Flip CLK_update once; on a tick-producing edge, check the update at N+2 and the hit pulse width.
   task automatic toggle_update(input string tag);
      logic lvl;
      bit   is_tick;
      exp_t e, o;
      lvl = ~clk_upd;
`ifdef SPRITE_TICK_BOTH_EDGES_EN
      is_tick = 1'b1;
`else
      is_tick = lvl;
`endif
      @(negedge clk);
      clk_upd = lvl;
      if (is_tick) begin
         model_step(1'b1, 1'b0, 1'b0, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         e = sb.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s update got %s exp %s", tag, fmt(o), fmt(e));
         end
         @(posedge clk);
         #1;
         checks++;
         if (ohit !== 1'b0) begin
            errors++;
            $display("FAIL %s hit_width got %b exp 0", tag, ohit);
         end
      end else begin
         @(posedge clk);
      end
   endtask

   // Apply control inputs in the same cycle the tick is high (between N+1 and N+2).
   task automatic ctrl_with_tick(input string tag, input logic st, input logic sp, input logic hm);
      exp_t e, o;
      @(negedge clk);
      clk_upd = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = st; stop = sp; home = hm;
      model_step(1'b1, st, sp, hm);
      @(posedge clk);
      #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL %s got %s exp %s", tag, fmt(o), fmt(e));
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0; home = 1'b0; clk_upd = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic pulse_ctrl(input string tag, input logic st, input logic sp, input logic hm);
      exp_t e, o;
      @(negedge clk);
      start = st; stop = sp; home = hm;
      model_step(1'b0, st, sp, hm);
      @(negedge clk);
      start = 1'b0; stop = 1'b0; home = 1'b0;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL %s got %s exp %s", tag, fmt(o), fmt(e));
      end
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst_n = 1'b0; clk_upd = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      e = '{x: 10'd100, y: 10'd100, dx: 1'b1, dy: 1'b1, run: 1'b0, hit: 1'b0};
      o = obs(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_state got %s exp %s", fmt(o), fmt(e));
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      model_step(1'b1, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_release_tick got %s exp %s", fmt(o), fmt(e));
      end
      @(negedge clk);
      clk_upd = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_start_latency();
      exp_t e, o;
      pulse_ctrl("start_run", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      clk_upd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sx !== 10'd100) begin
         errors++;
         $display("FAIL early_update got x=%0d exp 100", sx);
      end
      model_step(1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e || sx !== 10'd102 || sy !== 10'd102) begin
         errors++;
         $display("FAIL first_update got %s exp %s", fmt(o), fmt(e));
      end
      repeat (1000) @(posedge clk);
      #1;
      checks++;
      if (sx !== 10'd102 || sy !== 10'd102) begin
         errors++;
         $display("FAIL long_high got x=%0d y=%0d exp 102 102", sx, sy);
      end
      @(negedge clk);
      clk_upd = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_full_period();
      int x0;
      x0 = mx;
      toggle_update("period_rise");
      toggle_update("period_fall");
      repeat (3) @(posedge clk);
      #1;
      checks++;
`ifdef SPRITE_TICK_BOTH_EDGES_EN
      if (int'(sx) !== x0 + 4) begin
         errors++;
         $display("FAIL full_period got x=%0d exp %0d", sx, x0 + 4);
      end
`else
      if (int'(sx) !== x0 + 2) begin
         errors++;
         $display("FAIL full_period got x=%0d exp %0d", sx, x0 + 2);
      end
`endif
   endtask

   task automatic test_bounce_corner();
      bit done, x_hit_seen, expect_622;
      done = 1'b0; x_hit_seen = 1'b0; expect_622 = 1'b0;
      pulse_ctrl("bounce_home", 1'b0, 1'b0, 1'b1);
      pulse_ctrl("bounce_start", 1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 20000 && !done; i++) begin
         bit   will_tick;
         int   px, py;
         logic pdx, pdy;
`ifdef SPRITE_TICK_BOTH_EDGES_EN
         will_tick = 1'b1;
`else
         will_tick = (clk_upd == 1'b0);
`endif
         px = mx; py = my; pdx = mdx; pdy = mdy;
         toggle_update("bounce");
         if (will_tick) begin
            if (expect_622) begin
               checks++;
               if (sx !== 10'd622 || odx !== 1'b0) begin
                  errors++;
                  $display("FAIL after_right_edge got x=%0d dx=%b exp 622 0", sx, odx);
               end
               expect_622 = 1'b0;
            end
            if (!x_hit_seen && px == 622 && pdx) begin
               checks++;
               if (sx !== 10'd624 || odx !== 1'b0) begin
                  errors++;
                  $display("FAIL right_edge got x=%0d dx=%b exp 624 0", sx, odx);
               end
               x_hit_seen = 1'b1;
               expect_622 = 1'b1;
            end
            if (px == 622 && py == 462 && pdx && pdy) begin
               checks++;
               if (sx !== 10'd624 || sy !== 10'd464 || odx !== 1'b0 || ody !== 1'b0) begin
                  errors++;
                  $display("FAIL corner got x=%0d y=%0d dx=%b dy=%b exp 624 464 0 0", sx, sy, odx, ody);
               end
               done = 1'b1;
            end
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL corner_timeout got done=%b exp 1", done);
      end
      if (clk_upd) toggle_update("bounce_tail");
      repeat (3) @(posedge clk);
   endtask

   task automatic test_start_stop_same();
      pulse_ctrl("stop_run", 1'b0, 1'b1, 1'b0);
      pulse_ctrl("start_and_stop", 1'b1, 1'b1, 1'b0);
      toggle_update("idle_tick_rise");
      toggle_update("idle_tick_fall");
      repeat (3) @(posedge clk);
   endtask

   task automatic test_ctrl_tick();
      ctrl_with_tick("start_with_tick", 1'b1, 1'b0, 1'b0);
      ctrl_with_tick("stop_with_tick", 1'b0, 1'b1, 1'b0);
      pulse_ctrl("restart", 1'b1, 1'b0, 1'b0);
      ctrl_with_tick("home_with_tick", 1'b0, 1'b0, 1'b1);
      checks++;
      if (sx !== 10'd100 || sy !== 10'd100 || orun !== 1'b0) begin
         errors++;
         $display("FAIL home_state got x=%0d y=%0d run=%b exp 100 100 0", sx, sy, orun);
      end
   endtask

   task automatic test_reset_midrun();
      exp_t e, o;
      pulse_ctrl("midrun_start", 1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 4; i++) toggle_update("midrun_move");
      if (clk_upd) toggle_update("midrun_low");
      repeat (3) @(posedge clk);
      @(negedge clk);
      clk_upd = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      e = '{x: 10'd100, y: 10'd100, dx: 1'b1, dy: 1'b1, run: 1'b0, hit: 1'b0};
      o = obs(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL async_reset got %s exp %s", fmt(o), fmt(e));
      end
      @(negedge clk);
      clk_upd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      model_step(1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL after_reset got %s exp %s", fmt(o), fmt(e));
      end
   endtask

   initial begin
      test_reset();
      test_start_latency();
      test_full_period();
      test_bounce_corner();
      test_start_stop_same();
      test_ctrl_tick();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
